// File: rtl/pll_supervisor_pkg.sv
// Shared types and helpers for the PLL supervisor: FSM state encoding,
// counter widths and the window acceptance check.
package pll_supervisor_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 8;

    typedef enum logic [1:0] {
        PLL_RST,
        SETTLE,
        MEASURE,
        LOCKED
    } state_t;

    // Inclusive band check; the lower bound clamps at zero and the upper bound
    // is formed one bit wider so neither end can wrap.
    function automatic logic in_tolerance(
        input logic [CNT_W-1:0] count,
        input logic [CNT_W-1:0] expect_val,
        input logic [CNT_W-1:0] tol
    );
        logic [CNT_W:0] lo;
        logic [CNT_W:0] hi;
        lo = (expect_val >= tol) ? {1'b0, expect_val - tol} : '0;
        hi = {1'b0, expect_val} + {1'b0, tol};
        return ({1'b0, count} >= lo) && ({1'b0, count} <= hi);
    endfunction

endpackage

// File: rtl/async_edge_detect.sv
// Brings an asynchronous toggle into the clk domain and emits a one-cycle
// pulse for every rising or falling transition.
module async_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [1:0] sync;
    logic       dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            dly  <= sync[1];
        end
    end

    assign pulse = sync[1] ^ dly;

endmodule

// File: rtl/pll_supervisor.sv
// Holds the PLL in reset, lets it settle, then counts heartbeat edges over
// fixed refclk windows; releases system reset only after enough good windows.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 240,
    parameter int SETTLE_CYCLES  = 2400,
    parameter int WINDOW_CYCLES  = 2400,
    parameter int EXPECT_EDGES   = 338,
    parameter int TOLERANCE      = 8,
    parameter int GOOD_WINDOWS   = 4
) (
    input  logic               refclk,
    input  logic               reset_n,
    input  logic               heartbeat,
    output logic               pll_reset,
    output logic               sys_reset_n,
    output logic               locked,
    output logic [RETRY_W-1:0] retry_count,
    output logic [CNT_W-1:0]   last_edge_count
);

    state_t             state;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   good_cnt;
    logic               hb_edge;
    logic [CNT_W-1:0]   edge_next;
    logic [RETRY_W-1:0] retry_next;
    logic               window_end;
    logic               window_good;

    async_edge_detect u_hb_edge (
        .clk   (refclk),
        .rst_n (reset_n),
        .din   (heartbeat),
        .pulse (hb_edge)
    );

    // edge_next already includes an edge landing in the final window cycle
    assign edge_next   = (hb_edge && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign retry_next  = (retry_count == '1) ? retry_count : retry_count + RETRY_W'(1);
    assign window_end  = ((state == MEASURE) || (state == LOCKED)) &&
                         (cyc_cnt == CNT_W'(WINDOW_CYCLES - 1));
    assign window_good = in_tolerance(edge_next, CNT_W'(EXPECT_EDGES), CNT_W'(TOLERANCE));

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= PLL_RST;
            cyc_cnt         <= '0;
            edge_cnt        <= '0;
            good_cnt        <= '0;
            pll_reset       <= 1'b1;
            sys_reset_n     <= 1'b0;
            locked          <= 1'b0;
            retry_count     <= '0;
            last_edge_count <= '0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cyc_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state     <= SETTLE;
                        cyc_cnt   <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cyc_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state    <= MEASURE;
                        cyc_cnt  <= '0;
                        edge_cnt <= '0;
                        good_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                MEASURE, LOCKED: begin
                    if (window_end) begin
                        // next window starts immediately with a cleared count
                        cyc_cnt         <= '0;
                        edge_cnt        <= '0;
                        last_edge_count <= edge_next;
                        if (!window_good) begin
                            state       <= PLL_RST;
                            pll_reset   <= 1'b1;
                            locked      <= 1'b0;
                            sys_reset_n <= 1'b0;
                            good_cnt    <= '0;
                            retry_count <= retry_next;
                        end else if (state == MEASURE) begin
                            good_cnt <= good_cnt + CNT_W'(1);
                            if (good_cnt == CNT_W'(GOOD_WINDOWS - 1)) begin
                                state       <= LOCKED;
                                locked      <= 1'b1;
                                sys_reset_n <= 1'b1;
                            end
                        end
                    end else begin
                        cyc_cnt  <= cyc_cnt + CNT_W'(1);
                        edge_cnt <= edge_next;
                    end
                end
                default: state <= PLL_RST;
            endcase
        end
    end

endmodule
